fft16_out_serializer: RTL and testbench
=======================================

Name: fft16_out_serializer

Overview:
Output-side companion to the combinational 16-point DIT FFT. It captures one complete 16-bin complex frame from the FFT's parallel output bus and streams it out one bin per beat over a valid/ready interface to the host or capture logic. Two ping-pong banks let the FFT deliver the next frame while the current frame drains.

Parameters:
W, 16, signed sample width per real/imag component (Q1.15 at default)
CNT_W, 16, width of the completed-frame counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  parallel frame present on in_re_flat/in_im_flat
in_ready  out  1  a bank is free; frame accepted when in_valid && in_ready
in_re_flat  in  16*W  bin k real at [k*W +: W], signed
in_im_flat  in  16*W  bin k imag at [k*W +: W], signed
out_valid  out  1  out_* beat valid
out_ready  in  1  downstream accepts beat
out_re  out  W  current bin real, signed
out_im  out  W  current bin imag, signed
out_idx  out  4  FFT bin index of current beat
out_last  out  1  final beat of frame
frame_cnt  out  CNT_W  frames fully drained, wraps modulo 2^CNT_W

Behaviour:
- State: two banks of 16 x (2W) registers; full[1:0]; wr_bank; rd_bank; beat counter cnt[3:0]; frame_cnt.
- Reset (async, rst_n=0): full=0, wr_bank=0, rd_bank=0, cnt=0, frame_cnt=0. Bank contents are not reset. After reset: in_ready=1, out_valid=0, out_re=out_im=0, out_idx=0, out_last=0.
- in_ready = !full[wr_bank], purely from registers. There is no combinational path from out_ready to in_ready.
- Capture: on in_valid && in_ready, all 16 bins are written into bank wr_bank, full[wr_bank] is set, and wr_bank toggles. in_valid while !in_ready is ignored. Data is neither sampled nor lost, and the upstream side holds it.
- out_valid = full[rd_bank]. A frame accepted at edge k gives out_valid=1 in the cycle after edge k (latency 1).
- out_re/out_im/out_idx/out_last are combinational reads of registered state. While out_valid=0 they are forced to 0.
- Beat: on out_valid && out_ready, cnt increments. When cnt==15:
  - cnt returns to 0;
  - full[rd_bank] clears;
  - rd_bank toggles;
  - frame_cnt increments.
- out_last = out_valid && (cnt==15).
- Backpressure: while out_valid && !out_ready, all out_* hold stable.
- Both banks full: in_ready=0. A bank freed by the last beat at edge k is writable from the cycle after edge k.
- Capture into one bank and the last beat of the other bank on the same edge are both performed.
- Back-to-back frames with out_ready held at 1 give 16 beats per frame with no bubble between frames.
- Reset mid-frame discards both banks and any partial drain. The next frame starts at bin 0 in bank 0.
- No arithmetic on samples; bits pass through unchanged.

Optional Feature:
FFT16_SER_BITREV_EN.
- Defined: beat cnt reads bank entry bitrev4(cnt), and out_idx = bitrev4(cnt). Bin order is 0,8,4,12,2,10,...,15. out_last still fires on the 16th beat (cnt==15, bin 15).
- Undefined: natural order, entry cnt, with out_idx = cnt.

Decomposition:
- Shared package fft_pkg:
  - FFT_N=16, FFT_LOG2N=4, default W=16;
  - a bitrev4 function;
  - a typedef for a complex sample {re, im}.
- One sub-module, fft_frame_bank: a 16-entry x 2W register bank with a parallel write-enable load and a 4-bit combinational read index. It is instantiated twice.

Test Plan:
- Single frame: bin k = (k*100, -k). Present in_valid for 1 cycle with out_ready=1 -> out_valid rises the next cycle; 16 beats with out_re=0,100,...,1500, out_im=0,-1,...,-15, out_idx=0..15; out_last only on beat 16; frame_cnt 0->1.
- Backpressure: out_ready=0 for 5 cycles at beat 3 -> out_re=300 and out_idx=3 held stable; no beat lost or duplicated; 16 beats total.
- Ping-pong full: 3 frames offered back-to-back with out_ready=0 -> frames 1 and 2 accepted; in_ready=0 on the 3rd. Release out_ready -> in_ready=1 the cycle after frame 1's last beat. Output order is frame 1, 2, 3 with no inter-frame bubble.
- Extremes: bins 0x7FFF/0x8000 alternating -> output bit-exact, signs preserved.
- Reset mid-frame: assert rst_n=0 at beat 7 -> out_valid=0 and in_ready=1 immediately. The next frame starts at out_idx=0; frame_cnt=0.
- With FFT16_SER_BITREV_EN: frame bin k = k -> out_re sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15, with out_idx equal to out_re.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, complex sample type and bit-reversal helper for the 16-point FFT datapath.
package fft_pkg;

    localparam int FFT_N     = 16;
    localparam int FFT_LOG2N = 4;
    localparam int FFT_W     = 16;

    typedef struct packed {
        logic signed [FFT_W-1:0] re;
        logic signed [FFT_W-1:0] im;
    } cplx_t;

    function automatic logic [FFT_LOG2N-1:0] bitrev4(input logic [FFT_LOG2N-1:0] i);
        return {i[0], i[1], i[2], i[3]};
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One 16-bin complex frame store: parallel load of all bins, single combinational read port.
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int W = FFT_W
) (
    input  logic                 clk,
    input  logic                 load,
    input  logic [FFT_N*W-1:0]   re_flat,
    input  logic [FFT_N*W-1:0]   im_flat,
    input  logic [FFT_LOG2N-1:0] rd_idx,
    output logic [W-1:0]         rd_re,
    output logic [W-1:0]         rd_im
);

    logic [W-1:0] re_q [FFT_N];
    logic [W-1:0] im_q [FFT_N];

    // Data storage only; contents are meaningless until the owning full flag is set.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < FFT_N; k++) begin
                re_q[k] <= re_flat[k*W +: W];
                im_q[k] <= im_flat[k*W +: W];
            end
        end
    end

    assign rd_re = re_q[rd_idx];
    assign rd_im = im_q[rd_idx];

endmodule

// File: rtl/fft16_out_serializer.sv
// Ping-pong capture of a parallel 16-bin FFT frame, drained one bin per valid/ready beat.
// Define FFT16_SER_BITREV_EN to emit bins in bit-reversed order.
module fft16_out_serializer
    import fft_pkg::*;
#(
    parameter int W     = FFT_W,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FFT_N*W-1:0]   in_re_flat,
    input  logic [FFT_N*W-1:0]   in_im_flat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [W-1:0]  out_re,
    output logic signed [W-1:0]  out_im,
    output logic [FFT_LOG2N-1:0] out_idx,
    output logic                 out_last,
    output logic [CNT_W-1:0]     frame_cnt
);

    logic [1:0]           full_q, full_d;
    logic                 wr_bank_q, rd_bank_q;
    logic [FFT_LOG2N-1:0] cnt_q;
    logic [CNT_W-1:0]     frame_cnt_q;
    logic                 accept, beat, last_beat;
    logic [FFT_LOG2N-1:0] rd_idx;
    logic [W-1:0]         re0, im0, re1, im1;

    // in_ready depends only on registers, so no out_ready -> in_ready path exists.
    assign in_ready  = !full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign accept    = in_valid && in_ready;
    assign beat      = out_valid && out_ready;
    assign last_beat = beat && (cnt_q == 4'hf);
    assign frame_cnt = frame_cnt_q;

`ifdef FFT16_SER_BITREV_EN
    assign rd_idx = bitrev4(cnt_q);
`else
    assign rd_idx = cnt_q;
`endif

    fft_frame_bank #(.W(W)) u_bank0 (
        .clk     (clk),
        .load    (accept && !wr_bank_q),
        .re_flat (in_re_flat),
        .im_flat (in_im_flat),
        .rd_idx  (rd_idx),
        .rd_re   (re0),
        .rd_im   (im0)
    );

    fft_frame_bank #(.W(W)) u_bank1 (
        .clk     (clk),
        .load    (accept && wr_bank_q),
        .re_flat (in_re_flat),
        .im_flat (in_im_flat),
        .rd_idx  (rd_idx),
        .rd_re   (re1),
        .rd_im   (im1)
    );

    // Capture needs the write bank empty and the last beat needs the read bank full,
    // so on a shared edge they always touch different banks.
    always_comb begin
        full_d = full_q;
        if (last_beat) full_d[rd_bank_q] = 1'b0;
        if (accept)    full_d[wr_bank_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q      <= 2'b00;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            full_q <= full_d;
            if (accept) wr_bank_q <= !wr_bank_q;
            if (beat)   cnt_q <= cnt_q + 4'd1;
            if (last_beat) begin
                rd_bank_q   <= !rd_bank_q;
                frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        out_re   = '0;
        out_im   = '0;
        out_idx  = '0;
        out_last = 1'b0;
        if (out_valid) begin
            out_re   = rd_bank_q ? re1 : re0;
            out_im   = rd_bank_q ? im1 : im0;
            out_idx  = rd_idx;
            out_last = (cnt_q == 4'hf);
        end
    end

endmodule

// File: tb/tb_fft16_out_serializer.sv
// Directed bench for fft16_out_serializer with a beat scoreboard; honours FFT16_SER_BITREV_EN.
module tb_fft16_out_serializer;

    localparam int W = 16;
    localparam int N = 16;

    typedef struct {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic [3:0]   idx;
        logic         last;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [N*W-1:0]      in_re_flat;
    logic [N*W-1:0]      in_im_flat;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_re;
    logic signed [W-1:0] out_im;
    logic [3:0]          out_idx;
    logic                out_last;
    logic [15:0]         frame_cnt;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   beats  = 0;

    fft16_out_serializer #(.W(W), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_re_flat (in_re_flat),
        .in_im_flat (in_im_flat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_re     (out_re),
        .out_im     (out_im),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] beat_bin(input logic [3:0] c);
`ifdef FFT16_SER_BITREV_EN
        return {c[0], c[1], c[2], c[3]};
`else
        return c;
`endif
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a frame onto the parallel bus; kind selects the data pattern.
    task automatic set_frame(input int kind);
        for (int k = 0; k < N; k++) begin
            logic [W-1:0] re, im;
            case (kind)
                0: begin re = W'(k * 100); im = W'(-k); end
                1: begin re = W'(16'h1000 + k); im = W'(16'h2000 + k * 3); end
                2: begin re = W'(16'h5000 + k); im = W'(16'hA000 - k); end
                3: begin
                    re = (k % 2 == 0) ? 16'h7FFF : 16'h8000;
                    im = (k % 2 == 0) ? 16'h8000 : 16'h7FFF;
                end
                default: begin re = W'(k); im = W'(k); end
            endcase
            in_re_flat[k*W +: W] = re;
            in_im_flat[k*W +: W] = im;
        end
    endtask

    task automatic push_frame();
        for (int c = 0; c < N; c++) begin
            exp_t e;
            e.idx  = beat_bin(4'(c));
            e.re   = in_re_flat[e.idx*W +: W];
            e.im   = in_im_flat[e.idx*W +: W];
            e.last = (c == N - 1);
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a frame for exactly one cycle; the bus is idle on entry.
    task automatic send_frame(input int kind);
        set_frame(kind);
        in_valid = 1'b1;
        chk("in_ready_before_capture", 16'(in_ready), 16'd1);
        push_frame();
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            if (sb.size() == 0 && !out_valid) done = 1'b1;
        end
        chk(tag, 16'(done), 16'd1);
    endtask

    task automatic wait_beats(input int target);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (beats >= target) done = 1'b1;
            else tick();
        end
        chk("wait_beats_timeout", 16'(done), 16'd1);
    endtask

    // Scoreboard: a beat is presented at the negedge and consumed at the next posedge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_beat observed idx=%0d re=%0h", out_idx, out_re);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                assert ({out_re, out_im, out_idx, out_last} === {e.re, e.im, e.idx, e.last})
                else begin
                    errors++;
                    $error("FAIL beat observed re=%0h im=%0h idx=%0d last=%0b expected re=%0h im=%0h idx=%0d last=%0b",
                           out_re, out_im, out_idx, out_last, e.re, e.im, e.idx, e.last);
                end
            end
            beats++;
        end
    end

    initial begin
        int base;
        logic [15:0] hold_re;
        logic [3:0]  hold_idx;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        in_re_flat = '0;
        in_im_flat = '0;
        #2;
        chk("reset_in_ready", 16'(in_ready), 16'd1);
        chk("reset_out_valid", 16'(out_valid), 16'd0);
        chk("reset_out_re", out_re, 16'd0);
        chk("reset_out_im", out_im, 16'd0);
        chk("reset_out_idx", 16'(out_idx), 16'd0);
        chk("reset_out_last", 16'(out_last), 16'd0);
        chk("reset_frame_cnt", frame_cnt, 16'd0);
        #10;
        rst_n = 1'b1;
        tick();

        // Single frame, latency one cycle.
        chk("idle_out_valid", 16'(out_valid), 16'd0);
        send_frame(0);
        chk("latency_out_valid", 16'(out_valid), 16'd1);
        drain("drain_single");
        chk("frame_cnt_single", frame_cnt, 16'd1);

        // Backpressure at beat 3.
        base = beats;
        send_frame(0);
        wait_beats(base + 3);
        out_ready = 1'b0;
        hold_idx  = beat_bin(4'd3);
        hold_re   = 16'(hold_idx * 100);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 16'(out_valid), 16'd1);
            chk("bp_out_re", out_re, hold_re);
            chk("bp_out_idx", 16'(out_idx), 16'(hold_idx));
        end
        tick();
        out_ready = 1'b1;
        drain("drain_backpressure");
        chk("bp_beat_total", 16'(beats - base), 16'd16);
        chk("frame_cnt_bp", frame_cnt, 16'd2);

        // Ping-pong: both banks fill, third frame waits for the first bank to free.
        base = beats;
        out_ready = 1'b0;
        set_frame(1);
        in_valid = 1'b1;
        chk("pp_ready_f1", 16'(in_ready), 16'd1);
        push_frame();
        tick();
        set_frame(2);
        chk("pp_ready_f2", 16'(in_ready), 16'd1);
        push_frame();
        tick();
        set_frame(3);
        chk("pp_ready_full", 16'(in_ready), 16'd0);
        chk("pp_valid_full", 16'(out_valid), 16'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("pp_ready_draining", 16'(in_ready), 16'd0);
            tick();
        end
        chk("pp_ready_freed", 16'(in_ready), 16'd1);
        push_frame();
        tick();
        in_valid = 1'b0;
        repeat (31) tick();
        chk("pp_no_bubble_beats", 16'(beats - base), 16'd48);
        chk("pp_sb_empty", 16'(sb.size()), 16'd0);
        chk("pp_out_valid_idle", 16'(out_valid), 16'd0);
        chk("frame_cnt_pp", frame_cnt, 16'd5);

        // Ramp frame (bin k = k) exposes the read order directly.
        send_frame(4);
        drain("drain_ramp");
        chk("frame_cnt_ramp", frame_cnt, 16'd6);

        // Reset in the middle of a frame.
        base = beats;
        send_frame(0);
        wait_beats(base + 7);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 16'(out_valid), 16'd0);
        chk("rst_mid_in_ready", 16'(in_ready), 16'd1);
        chk("rst_mid_frame_cnt", frame_cnt, 16'd0);
        chk("rst_mid_out_last", 16'(out_last), 16'd0);
        sb.delete();
        #1;
        rst_n = 1'b1;
        tick();
        chk("post_rst_out_valid", 16'(out_valid), 16'd0);
        send_frame(2);
        chk("post_rst_first_idx", 16'(out_idx), 16'd0);
        drain("drain_post_reset");
        chk("frame_cnt_post_reset", frame_cnt, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
